// File: rtl/mem_32x16_if.sv
// Bus bundle for the 32x16 scratch SRAM: operation strobe, address, write data, read data.
interface mem_32x16_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              r_w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;

    modport master (
        output r_w,
        output addr,
        output d_in,
        input  d_out
    );

    modport slave (
        input  r_w,
        input  addr,
        input  d_in,
        output d_out
    );
endinterface

// File: rtl/mem_32x16.sv
// Single-port 32x16 synchronous SRAM with registered read data.
// Async active-low reset clears the whole array and the output register.
module mem_32x16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_32x16_if.slave      bus
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] word_sel;

    assign word_sel = bus.addr;

    // Reset clears storage too, so no location can ever read back X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.r_w) begin
            mem[word_sel] <= bus.d_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.d_out <= '0;
        end else if (!bus.r_w) begin
            bus.d_out <= mem[word_sel];
        end
    end
endmodule

// File: tb/tb_mem_32x16.sv
// Self-checking bench for mem_32x16: directed vector table, hand-written reset and
// mid-cycle address sequences, and random traffic against an array reference model.
module tb_mem_32x16;
    typedef struct packed {
        logic        r_w;
        logic [4:0]  addr;
        logic [15:0] d_in;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [15:0] model_mem [32];
    logic [15:0] model_out;

    mem_32x16_if #(.DATA_W(16), .ADDR_W(5)) bus ();

    mem_32x16 #(.DATA_W(16), .ADDR_W(5), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] exp);
        total++;
        if (bus.d_out !== exp) begin
            bad++;
            $display("[TB] FAIL %s: d_out=%h expected=%h", name, bus.d_out, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_mem[i] = 16'h0000;
        model_out = 16'h0000;
    endtask

    // Drive one operation from the falling edge, let the rising edge take it, sample 1ns later.
    task automatic apply_stimulus(input logic r_w, input logic [4:0] addr, input logic [15:0] d_in);
        @(negedge clk);
        bus.r_w  = r_w;
        bus.addr = addr;
        bus.d_in = d_in;
        @(posedge clk);
        #1;
        if (r_w) model_mem[addr] = d_in;
        else     model_out = model_mem[addr];
    endtask

    vec_t vecs [17];

    initial begin
        total = 0;
        bad   = 0;
        rst      = 1'b0;
        bus.r_w  = 1'b0;
        bus.addr = '0;
        bus.d_in = '0;
        model_reset();

        // Plan items 2-4 with hand-derived expectations.
        vecs[0]  = '{1'b1, 5'd7,  16'hCC33, 16'h0000};
        vecs[1]  = '{1'b1, 5'd2,  16'h5577, 16'h0000};
        vecs[2]  = '{1'b1, 5'd14, 16'h1464, 16'h0000};
        vecs[3]  = '{1'b1, 5'd6,  16'h1144, 16'h0000};
        vecs[4]  = '{1'b0, 5'd7,  16'h0000, 16'hCC33};
        vecs[5]  = '{1'b0, 5'd14, 16'h0000, 16'h1464};
        vecs[6]  = '{1'b0, 5'd6,  16'h0000, 16'h1144};
        vecs[7]  = '{1'b0, 5'd2,  16'h0000, 16'h5577};
        vecs[8]  = '{1'b0, 5'd7,  16'h0000, 16'hCC33};
        vecs[9]  = '{1'b1, 5'd3,  16'hBEEF, 16'hCC33};
        vecs[10] = '{1'b0, 5'd3,  16'h0000, 16'hBEEF};
        vecs[11] = '{1'b1, 5'd0,  16'hFFFF, 16'hBEEF};
        vecs[12] = '{1'b1, 5'd31, 16'hA5A5, 16'hBEEF};
        vecs[13] = '{1'b1, 5'd31, 16'h0001, 16'hBEEF};
        vecs[14] = '{1'b0, 5'd0,  16'h0000, 16'hFFFF};
        vecs[15] = '{1'b0, 5'd31, 16'h0000, 16'h0001};
        vecs[16] = '{1'b0, 5'd14, 16'h0000, 16'h1464};

        // Reset held across two edges with a write pending: reset must win.
        bus.r_w  = 1'b1;
        bus.addr = 5'd9;
        bus.d_in = 16'h7777;
        #1;
        check_output("reset_async_out", 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_held_out", 16'h0000);
        @(negedge clk);
        rst     = 1'b1;
        bus.r_w = 1'b0;

        apply_stimulus(1'b0, 5'd0, 16'h0);
        check_output("reset_read_0", 16'h0000);
        apply_stimulus(1'b0, 5'd7, 16'h0);
        check_output("reset_read_7", 16'h0000);
        apply_stimulus(1'b0, 5'd31, 16'h0);
        check_output("reset_read_31", 16'h0000);
        apply_stimulus(1'b0, 5'd9, 16'h0);
        check_output("reset_write_blocked", 16'h0000);

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].r_w, vecs[i].addr, vecs[i].d_in);
            check_output($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Async reset between edges with stored data present.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_output("async_reset_no_edge", 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        apply_stimulus(1'b0, 5'd7, 16'h0);
        check_output("post_reset_read_7", 16'h0000);
        apply_stimulus(1'b0, 5'd31, 16'h0);
        check_output("post_reset_read_31", 16'h0000);
        apply_stimulus(1'b0, 5'd3, 16'h0);
        check_output("post_reset_read_3", 16'h0000);

        // Address wiggles between edges must not reach d_out.
        apply_stimulus(1'b1, 5'd4, 16'h1111);
        apply_stimulus(1'b1, 5'd5, 16'h2222);
        apply_stimulus(1'b0, 5'd4, 16'h0);
        check_output("addr_mid_read_4", 16'h1111);
        @(negedge clk);
        bus.addr = 5'd5;
        #1;
        check_output("addr_mid_no_comb", 16'h1111);
        bus.addr = 5'd4;
        #1;
        check_output("addr_mid_no_comb2", 16'h1111);
        bus.addr = 5'd5;
        @(posedge clk);
        #1;
        model_out = model_mem[5];
        check_output("addr_sampled_at_edge", 16'h2222);
        bus.addr = 5'd4;
        #2;
        check_output("addr_after_edge_hold", 16'h2222);

        // Random traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
            check_output($sformatf("rand%0d", n), model_out);
        end
        for (int a = 0; a < 32; a++) begin
            apply_stimulus(1'b0, 5'(a), 16'h0);
            check_output($sformatf("sweep%0d", a), model_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
